// File: rtl/jt08_adpcmb_enc_if.sv
// Sample stream and RAM write bus of the ADPCM-B encoder.
// master: encoder side (accepts PCM samples, drives nibbles and RAM writes).
// slave : environment side (sample source, RAM arbiter, nibble monitor).
interface jt08_adpcmb_enc_if;
    logic signed [15:0] pcm_in;
    logic               pcm_valid;
    logic               pcm_ready;
    logic        [3:0]  nibble_out;
    logic               nibble_valid;
    logic        [20:0] addr;
    logic        [7:0]  ram_dout;
    logic               ram_wr_n;
    logic               busy;

    modport master (
        input  pcm_in, pcm_valid,
        output pcm_ready, nibble_out, nibble_valid, addr, ram_dout, ram_wr_n, busy
    );

    modport slave (
        output pcm_in, pcm_valid,
        input  pcm_ready, nibble_out, nibble_valid, addr, ram_dout, ram_wr_n, busy
    );
endinterface

// File: rtl/jt08_adpcmb_enc.sv
// ADPCM-B encoder: quantises signed 16-bit PCM into Yamaha ADPCM-B nibbles,
// tracking the same predictor (x) and step size (delta) as the playback
// decoder, packs two nibbles per byte (high first) and writes the bytes to
// ADPCM RAM between astart and astop.
module jt08_adpcmb_enc #(
    parameter int WRWAIT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic        enc_on,
    input  logic [20:0] astart,
    input  logic [20:0] astop,
    input  logic        arepeat,
    input  logic        clr_eos,
    output logic        eos,
    jt08_adpcmb_enc_if.master bus
);
    localparam int DATA_W = 16;
    localparam int WCNT_W = (WRWAIT > 1) ? $clog2(WRWAIT) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WRWAIT - 1);
    localparam logic [14:0] DELTA_MIN = 15'd127;
    localparam logic [14:0] DELTA_MAX = 15'd24576;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_QUANT,
        ST_UPDATE,
        ST_WRITE,
        ST_POST,
        ST_DONE
    } state_t;

    state_t state, state_nx;

    // Control / architectural state
    logic                     enc_on_q;
    logic                     half;
    logic [WCNT_W-1:0]        wcnt;
    logic signed [DATA_W-1:0] x;
    logic [14:0]              delta;
    logic [3:0]               nibble_out;
    logic                     nibble_valid;
    logic [20:0]              addr;
    logic [7:0]               ram_dout;
    logic                     ram_wr_n;
    logic                     busy;
    logic                     pcm_ready;

    // Datapath registers (no reset needed: always written before use)
    logic signed [DATA_W-1:0] pcm_p0;
    logic [2:0]               l_p1;
    logic                     sgn_p1;
    logic [3:0]               held;

    logic                     accept;
    logic                     at_stop;
    logic                     wr_last;

    logic signed [16:0]       diff;
    logic [16:0]              mag;
    logic [16:0]              dl17;
    logic [16:0]              rem1;
    logic [16:0]              rem2;
    logic                     q2;
    logic                     q1;
    logic                     q0;

    logic [18:0]              step_prod;
    logic [15:0]              step_d;
    logic signed [17:0]       x_sum;
    logic signed [DATA_W-1:0] x_nx;
    logic [21:0]              delta_prod;
    logic [14:0]              delta_nx;

    function automatic logic signed [DATA_W-1:0] sat_x(input logic signed [17:0] v);
        if (v > 18'sd32767)
            return 16'sh7fff;
        else if (v < -18'sd32768)
            return 16'sh8000;
        else
            return $signed(v[15:0]);
    endfunction

    function automatic logic [14:0] sat_delta(input logic [15:0] v);
        if (v < 16'(DELTA_MIN))
            return DELTA_MIN;
        else if (v > 16'(DELTA_MAX))
            return DELTA_MAX;
        else
            return v[14:0];
    endfunction

    function automatic logic [7:0] step_mult(input logic [2:0] l);
        case (l)
            3'd4:    return 8'd77;
            3'd5:    return 8'd102;
            3'd6:    return 8'd128;
            3'd7:    return 8'd153;
            default: return 8'd57;
        endcase
    endfunction

    // A rising edge of enc_on must be seen (enc_on_q high) before samples flow,
    // so the first accepted sample always follows initialisation.
    assign pcm_ready = (state == ST_IDLE) && enc_on && enc_on_q;
    assign accept    = cen && bus.pcm_valid && pcm_ready;
    assign at_stop   = (addr == astop);
    assign wr_last   = (wcnt == WCNT_LAST);

    // Quantiser: successive-approximation of |pcm - x| against delta, delta/2, delta/4
    always_comb begin
        diff = $signed({pcm_p0[15], pcm_p0}) - $signed({x[15], x});
        mag  = diff[16] ? $unsigned(-diff) : $unsigned(diff);
        dl17 = {2'b00, delta};
        q2   = (mag >= dl17);
        rem1 = q2 ? (mag - dl17) : mag;
        q1   = (rem1 >= (dl17 >> 1));
        rem2 = q1 ? (rem1 - (dl17 >> 1)) : rem1;
        q0   = (rem2 >= (dl17 >> 2));
    end

    // Predictor / step-size update, mirrors the decoder's reconstruction
    always_comb begin
        step_prod  = 19'({l_p1, 1'b1}) * 19'(delta);
        step_d     = step_prod[18:3];
        x_sum      = sgn_p1 ? ($signed({{2{x[15]}}, x}) - $signed({2'b00, step_d}))
                            : ($signed({{2{x[15]}}, x}) + $signed({2'b00, step_d}));
        x_nx       = sat_x(x_sum);
        delta_prod = 22'(delta) * 22'(step_mult(l_p1));
        delta_nx   = sat_delta(delta_prod[21:6]);
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    // FSM next-state logic
    always_comb begin
        state_nx = state;
        if (cen) begin
            case (state)
                ST_IDLE:   if (bus.pcm_valid && pcm_ready) state_nx = ST_QUANT;
                ST_QUANT:  state_nx = enc_on ? ST_UPDATE : ST_IDLE;
                ST_UPDATE: state_nx = (enc_on && half) ? ST_WRITE : ST_IDLE;
                ST_WRITE:  if (wr_last) state_nx = ST_POST;
                ST_POST:   state_nx = (at_stop && !arepeat) ? ST_DONE : ST_IDLE;
                ST_DONE:   if (!enc_on) state_nx = ST_IDLE;
                default:   state_nx = ST_IDLE;
            endcase
        end
    end

    // Predictor state, nibble output, byte packing, RAM strobe and address walk
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enc_on_q     <= 1'b0;
            half         <= 1'b0;
            wcnt         <= '0;
            x            <= '0;
            delta        <= DELTA_MIN;
            nibble_out   <= '0;
            nibble_valid <= 1'b0;
            addr         <= '0;
            ram_dout     <= '0;
            ram_wr_n     <= 1'b1;
            busy         <= 1'b0;
            eos          <= 1'b0;
        end else if (cen) begin
            enc_on_q     <= enc_on;
            nibble_valid <= 1'b0;
            case (state)
                ST_IDLE, ST_QUANT: begin
                    if (!enc_on) half <= 1'b0;
                end
                ST_UPDATE: begin
                    if (!enc_on) begin
                        half <= 1'b0;
                    end else begin
                        x            <= x_nx;
                        delta        <= delta_nx;
                        nibble_out   <= {sgn_p1, l_p1};
                        nibble_valid <= 1'b1;
                        half         <= ~half;
                        if (half) begin
                            ram_dout <= {held, sgn_p1, l_p1};
                            ram_wr_n <= 1'b0;
                            busy     <= 1'b1;
                            wcnt     <= '0;
                        end
                    end
                end
                ST_WRITE: begin
                    if (wr_last) begin
                        ram_wr_n <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        wcnt <= wcnt + WCNT_W'(1);
                    end
                end
                ST_POST: begin
                    if (at_stop) begin
                        if (arepeat) addr <= astart;
                    end else begin
                        addr <= addr + 21'd1;
                    end
                end
                default: ;
            endcase
            // Setting eos wins over a simultaneous clear
            if (state == ST_POST && at_stop)
                eos <= 1'b1;
            else if (clr_eos)
                eos <= 1'b0;
            // Re-initialisation on enc_on rising edge; eos deliberately untouched
            if (enc_on && !enc_on_q) begin
                addr  <= astart;
                x     <= '0;
                delta <= DELTA_MIN;
                half  <= 1'b0;
            end
        end
    end

    // Sample capture, quantiser result and pending high nibble
    always_ff @(posedge clk) begin
        if (accept)
            pcm_p0 <= bus.pcm_in;
        if (cen && state == ST_QUANT) begin
            l_p1   <= {q2, q1, q0};
            sgn_p1 <= diff[16];
        end
        if (cen && state == ST_UPDATE && enc_on && !half)
            held <= {sgn_p1, l_p1};
    end

    assign bus.pcm_ready    = pcm_ready;
    assign bus.nibble_out   = nibble_out;
    assign bus.nibble_valid = nibble_valid;
    assign bus.addr         = addr;
    assign bus.ram_dout     = ram_dout;
    assign bus.ram_wr_n     = ram_wr_n;
    assign bus.busy         = busy;
endmodule

// File: tb/tb_jt08_adpcmb_enc.sv
// Self-checking bench for jt08_adpcmb_enc: directed and randomised sample
// streams compared against an integer ADPCM-B reference model.
module tb_jt08_adpcmb_enc;
    localparam int WRWAIT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        cen;
    logic        enc_on;
    logic [20:0] astart;
    logic [20:0] astop;
    logic        arepeat;
    logic        clr_eos;
    logic        eos;

    jt08_adpcmb_enc_if bus ();

    jt08_adpcmb_enc #(.WRWAIT(WRWAIT)) dut (
        .clk    (clk),
        .rst    (rst),
        .cen    (cen),
        .enc_on (enc_on),
        .astart (astart),
        .astop  (astop),
        .arepeat(arepeat),
        .clr_eos(clr_eos),
        .eos    (eos),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit gaps = 0;
    bit clr_at_post = 0;
    int TBL[8] = '{57, 57, 57, 57, 77, 102, 128, 153};

    // Reference model state
    int         mx;
    int         mdelta;
    int         maddr;
    bit         mhalf;
    bit         meos;
    bit         mdone;
    logic [3:0] mheld;
    logic [3:0] last_nib;
    logic [7:0] dut_byte;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One enabled cycle, optionally preceded by random idle (cen=0) clocks
    task automatic step();
        if (gaps) begin
            int n;
            n = $urandom_range(0, 2);
            cen = 1'b0;
            repeat (n) tick();
        end
        cen = 1'b1;
        tick();
    endtask

    function automatic logic [3:0] model_encode(input int pcm);
        int diff, m, l, d;
        bit s;
        diff = pcm - mx;
        s    = (diff < 0);
        m    = s ? -diff : diff;
        l    = 0;
        if (m >= mdelta)     begin l += 4; m -= mdelta;     end
        if (m >= mdelta / 2) begin l += 2; m -= mdelta / 2; end
        if (m >= mdelta / 4) l += 1;
        d  = ((2 * l + 1) * mdelta) / 8;
        mx = s ? mx - d : mx + d;
        if (mx > 32767)  mx = 32767;
        if (mx < -32768) mx = -32768;
        mdelta = (mdelta * TBL[l]) / 64;
        if (mdelta < 127)   mdelta = 127;
        if (mdelta > 24576) mdelta = 24576;
        return {s, 3'(l)};
    endfunction

    function automatic int rand_pcm();
        logic signed [15:0] r;
        case ($urandom_range(0, 3))
            0:       r = 16'($urandom);
            1:       r = 16'(mx + int'($urandom_range(0, 400)) - 200);
            2:       r = ($urandom_range(0, 1) == 1) ? 16'sh7fff : 16'sh8000;
            default: r = '0;
        endcase
        return int'(r);
    endfunction

    task automatic enable();
        enc_on = 1'b0;
        step();
        enc_on = 1'b1;
        step();
        mx = 0; mdelta = 127; mhalf = 0; maddr = int'(astart); mdone = 0;
        chk("init_addr", bus.addr, astart);
        chk("init_ready", bus.pcm_ready, 1);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (bus.pcm_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("ready", bus.pcm_ready, 1);
    endtask

    // Full sample transaction with nibble, byte write and address checks
    task automatic send(input int pcm);
        logic [3:0] en;
        wait_ready();
        bus.pcm_in    = 16'(pcm);
        bus.pcm_valid = 1'b1;
        step();
        bus.pcm_valid = 1'b0;
        en = model_encode(pcm);
        step();
        chk("nv_quant", bus.nibble_valid, 0);
        step();
        last_nib = bus.nibble_out;
        chk("nibble", bus.nibble_out, en);
        chk("nv_pulse", bus.nibble_valid, 1);
        if (!mhalf) begin
            mheld = en;
            mhalf = 1;
            chk("wr_idle", bus.ram_wr_n, 1);
        end else begin
            mhalf    = 0;
            dut_byte = bus.ram_dout;
            chk("wr_low", bus.ram_wr_n, 0);
            chk("busy", bus.busy, 1);
            chk("byte", bus.ram_dout, {mheld, en});
            chk("wr_addr", bus.addr, maddr);
            repeat (WRWAIT - 1) begin
                step();
                chk("wr_hold", bus.ram_wr_n, 0);
            end
            step();
            chk("wr_rise", bus.ram_wr_n, 1);
            chk("busy_end", bus.busy, 0);
            clr_eos = clr_at_post;
            step();
            clr_eos = 1'b0;
            if (maddr == int'(astop)) begin
                meos = 1;
                if (arepeat) maddr = int'(astart);
                else         mdone = 1;
            end else begin
                if (clr_at_post) meos = 0;
                maddr = (maddr + 1) & 32'h1FFFFF;
            end
            chk("post_addr", bus.addr, maddr);
            chk("post_eos", eos, meos);
            chk("post_ready", bus.pcm_ready, mdone ? 0 : 1);
        end
    endtask

    initial begin
        rst = 1'b1; cen = 1'b0; enc_on = 1'b0; arepeat = 1'b0; clr_eos = 1'b0;
        astart = '0; astop = '0;
        bus.pcm_in = '0; bus.pcm_valid = 1'b0;
        meos = 0;
        repeat (3) tick();
        chk("rst_ready", bus.pcm_ready, 0);
        chk("rst_nib", bus.nibble_out, 0);
        chk("rst_nv", bus.nibble_valid, 0);
        chk("rst_addr", bus.addr, 0);
        chk("rst_dout", bus.ram_dout, 0);
        chk("rst_wr_n", bus.ram_wr_n, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_eos", eos, 0);
        rst = 1'b0;
        tick();

        // Two zero samples
        astart = 21'h100; astop = 21'h1FF; arepeat = 1'b0;
        enable();
        send(0);
        chk("zero_nib0", last_nib, 4'h0);
        send(0);
        chk("zero_nib1", last_nib, 4'h8);
        chk("zero_byte", dut_byte, 8'h08);
        chk("zero_addr", bus.addr, 21'h101);

        // Full-scale positive pair
        enable();
        send(32767);
        chk("pos_nib0", last_nib, 4'h7);
        send(32767);
        chk("pos_byte", dut_byte, 8'h77);

        // Sustained extremes: predictor saturation both ways, delta ceiling
        enable();
        repeat (40) send(-32768);
        enable();
        repeat (40) send(32767);
        enable();
        for (int i = 0; i < 20; i++) send((i % 2 == 1) ? 32767 : -32768);

        // Single-byte region without repeat: one write then halt
        astart = 21'h10; astop = 21'h10; arepeat = 1'b0;
        enable();
        send(100);
        send(-100);
        bus.pcm_in = 16'sd5; bus.pcm_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("done_ready", bus.pcm_ready, 0);
            chk("done_wr_n", bus.ram_wr_n, 1);
        end
        bus.pcm_valid = 1'b0;

        // Same region with repeat: writes keep landing at the start address
        arepeat = 1'b1;
        enable();
        chk("eos_sticky", eos, meos);
        clr_eos = 1'b1; step(); clr_eos = 1'b0; meos = 0;
        chk("eos_clr", eos, 0);
        repeat (4) send($urandom_range(0, 2000));
        chk("rep_addr", bus.addr, 21'h10);
        clr_eos = 1'b1; step(); clr_eos = 1'b0; meos = 0;
        chk("eos_clr2", eos, 0);
        clr_at_post = 1'b1;
        send(-700);
        send(900);
        clr_at_post = 1'b0;
        chk("eos_prio", eos, 1);
        clr_eos = 1'b1; step(); clr_eos = 1'b0; meos = 0;
        chk("eos_late_clr", eos, 0);
        send(10);
        send(20);

        // Randomised streams with idle clocks, address wrap at 0x1FFFFF
        gaps = 1'b1;
        astart = 21'h1FFFFE; astop = 21'h000001; arepeat = 1'b1;
        enable();
        for (int i = 0; i < 30; i++) send(rand_pcm());
        astart = 21'($urandom_range(0, 21'h1FFFF0));
        astop  = astart + 21'd3;
        enable();
        for (int i = 0; i < 30; i++) send(rand_pcm());
        gaps = 1'b0;
        chk("eos_before_rst", eos, meos);

        // Asynchronous reset during a byte write
        astart = 21'h200; astop = 21'h2FF; arepeat = 1'b0;
        enable();
        send(1000);
        wait_ready();
        bus.pcm_in = 16'sd2000; bus.pcm_valid = 1'b1;
        step();
        bus.pcm_valid = 1'b0;
        step();
        step();
        chk("arst_pre_wr", bus.ram_wr_n, 0);
        #2 rst = 1'b1;
        #1;
        chk("arst_wr_n", bus.ram_wr_n, 1);
        chk("arst_busy", bus.busy, 0);
        chk("arst_addr", bus.addr, 0);
        chk("arst_eos", eos, 0);
        chk("arst_ready", bus.pcm_ready, 0);
        repeat (2) tick();
        rst = 1'b0;
        meos = 0;
        step();
        mx = 0; mdelta = 127; mhalf = 0; maddr = int'(astart); mdone = 0;
        chk("restart_addr", bus.addr, 21'h200);
        chk("restart_ready", bus.pcm_ready, 1);
        send(300);
        send(-300);
        chk("restart_next", bus.addr, 21'h201);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, tests %0d failed %0d", tests, fails);
        $fatal(1, "timeout");
    end
endmodule
